// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program ROM port, instruction output to the decoder,
// and the decoder feedback flags that steer the PC.
//
// Transfer semantics: there is no ready/backpressure. In every cycle where
// instr_valid is high, instr/pc are one real program line. The decoder must
// consume that line and return its flags combinationally in the same cycle.
// When instr_valid is low, instr is all-zero (NOP) and the flags are ignored
// outside the RUN state.
interface instr_fetch_if #(
  parameter int ADDR_W = 4,
  parameter int SLP_W  = 11
);
  logic [ADDR_W-1:0]       rom_addr;
  logic [30:0]             rom_data;
  logic [30:0]             instr;
  logic                    instr_valid;
  logic [ADDR_W-1:0]       pc;
  logic                    sleeping;
  logic                    is_jmp;
  logic                    is_slp;
  logic                    slp_use_imm;
  logic signed [SLP_W-1:0] slp_reg_val;
  logic [1:0]              state_dbg;

  // Fetch stage side.
  modport master (
    output rom_addr, instr, instr_valid, pc, sleeping, state_dbg,
    input  rom_data, is_jmp, is_slp, slp_use_imm, slp_reg_val
  );

  // ROM / decoder side.
  modport slave (
    input  rom_addr, instr, instr_valid, pc, sleeping, state_dbg,
    output rom_data, is_jmp, is_slp, slp_use_imm, slp_reg_val
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: owns the PC, addresses a combinational
// program ROM and registers the fetched line for the decoder. Decoder
// feedback redirects the PC (jump) or stalls the stage for n cycles (sleep).
module instr_fetch #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int SLP_W      = 11
) (
  input  logic        clk,
  input  logic        reset,
  instr_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);
  // One bit wider than the PC so PROG_DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(PROG_DEPTH);
  localparam logic [SLP_W-2:0]  CNT_ONE = (SLP_W - 1)'(1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [30:0]             instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    sleeping_q, sleeping_d;
  logic [SLP_W-2:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0]       pc_next;
  logic [ADDR_W-1:0]       jmp_tgt;
  logic [ADDR_W-1:0]       rom_addr_c;
  logic signed [SLP_W-1:0] slp_n;
  logic                    slp_pos;

  // Operand decode from the currently presented line.
  always_comb begin
    pc_next = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
    // Out-of-range jump targets fold to line 0.
    jmp_tgt = ({1'b0, instr_q[ADDR_W-1:0]} >= DEPTH_X) ? '0 : instr_q[ADDR_W-1:0];
    slp_n   = bus.slp_use_imm ? signed'(instr_q[SLP_W-1:0]) : bus.slp_reg_val;
    slp_pos = !slp_n[SLP_W-1] && (slp_n != '0);
  end

  // Next-state, ROM address and next-output logic for the BOOT/RUN/SLEEP FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    sleeping_d = sleeping_q;
    cnt_d      = cnt_q;
    rom_addr_c = pc_next;
    unique case (state_q)
      ST_BOOT: begin
        rom_addr_c = '0;
        instr_d    = bus.rom_data;
        pc_d       = '0;
        valid_d    = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (bus.is_jmp) begin
          rom_addr_c = jmp_tgt;
          instr_d    = bus.rom_data;
          pc_d       = jmp_tgt;
        end else if (bus.is_slp && slp_pos) begin
          // Stall: present NOP, keep pc on the SLP line while counting down.
          state_d    = ST_SLEEP;
          cnt_d      = slp_n[SLP_W-2:0];
          instr_d    = '0;
          valid_d    = 1'b0;
          sleeping_d = 1'b1;
        end else begin
          instr_d = bus.rom_data;
          pc_d    = pc_next;
        end
      end
      ST_SLEEP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) begin
          instr_d    = bus.rom_data;
          pc_d       = pc_next;
          valid_d    = 1'b1;
          sleeping_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      sleeping_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      sleeping_q <= sleeping_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rom_addr    = rom_addr_c;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.sleeping    = sleeping_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a 16-line instance driven from a vector table,
// and a 12-line instance driven by a hand-written sequence for the
// out-of-range jump target and the short-program wrap.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst16 = 1'b1;
  logic rst12 = 1'b1;

  logic [30:0] rom16 [16];
  logic [30:0] rom12 [16];

  instr_fetch_if #(.ADDR_W(4), .SLP_W(11)) if16 ();
  instr_fetch_if #(.ADDR_W(4), .SLP_W(11)) if12 ();

  assign if16.rom_data = rom16[if16.rom_addr];
  assign if12.rom_data = rom12[if12.rom_addr];

  instr_fetch #(.PROG_DEPTH(16), .ADDR_W(4), .SLP_W(11)) dut (
    .clk   (clk),
    .reset (rst16),
    .bus   (if16)
  );

  instr_fetch #(.PROG_DEPTH(12), .ADDR_W(4), .SLP_W(11)) dut12 (
    .clk   (clk),
    .reset (rst12),
    .bus   (if12)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        jmp;
    logic        slp;
    logic        imm;
    logic [10:0] rv;
    logic [3:0]  addr;
    logic [3:0]  pc;
    logic [30:0] instr;
    logic        valid;
    logic        sl;
  } vec_t;

  vec_t        vecs[$];
  logic [36:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rom_change_idx = 0;

  function automatic vec_t mk(logic rst, logic jmp, logic slp, logic imm, int rv,
                              int addr, int pc, int instr, logic valid, logic sl);
    vec_t v;
    v.rst   = rst;
    v.jmp   = jmp;
    v.slp   = slp;
    v.imm   = imm;
    v.rv    = 11'(rv);
    v.addr  = 4'(addr);
    v.pc    = 4'(pc);
    v.instr = 31'(instr);
    v.valid = valid;
    v.sl    = sl;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Reset, then boot and step to pc=2 (which holds 0x003).
  task automatic push_boot2(input int rst_addr);
    vecs.push_back(mk(1, 0, 0, 0, 0, rst_addr, 0, 'h000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h101, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 2, 'h003, 1, 0));
  endtask

  // Drive one vector at the falling edge, check the ROM address, then check
  // the registered outputs at the next falling edge.
  task automatic apply16(input vec_t v, input int idx);
    logic [36:0] e;
    rst16            = v.rst;
    if16.is_jmp      = v.jmp;
    if16.is_slp      = v.slp;
    if16.slp_use_imm = v.imm;
    if16.slp_reg_val = v.rv;
    #1;
    chk("rom_addr16", idx, 64'(if16.rom_addr), 64'(v.addr));
    exp_q.push_back({v.pc, v.instr, v.valid, v.sl});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("out16{pc,instr,valid,sleeping}", idx,
        64'({if16.pc, if16.instr, if16.instr_valid, if16.sleeping}), 64'(e));
  endtask

  task automatic step12(input logic rst, input logic jmp, input int addr,
                        input int pc, input int instr, input logic valid, input int idx);
    logic [36:0] e;
    rst12       = rst;
    if12.is_jmp = jmp;
    #1;
    chk("rom_addr12", idx, 64'(if12.rom_addr), 64'(addr));
    exp_q.push_back({4'(pc), 31'(instr), valid, 1'b0});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("out12{pc,instr,valid,sleeping}", idx,
        64'({if12.pc, if12.instr, if12.instr_valid, if12.sleeping}), 64'(e));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      rom16[k] = 31'(32'h100 + k);
      rom12[k] = 31'(32'h100 + k);
    end
    rom12[1] = 31'h00F;
    if16.is_jmp = 0; if16.is_slp = 0; if16.slp_use_imm = 0; if16.slp_reg_val = '0;
    if12.is_jmp = 0; if12.is_slp = 0; if12.slp_use_imm = 0; if12.slp_reg_val = '0;

    // Boot and sequential run through the wrap 15 -> 0.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h100, 1, 0));
    for (int j = 1; j <= 16; j++)
      vecs.push_back(mk(0, 0, 0, 0, 0, j % 16, j % 16, 'h100 + (j % 16), 1, 0));
    rom_change_idx = vecs.size();
    // Jump 3 -> 9, busy-loop jump 10 -> 10, then reset.
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h101, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 2, 'h003, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 3, 'h109, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 9, 9, 'h109, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10, 10, 'h10A, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 10, 10, 'h10A, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 11, 11, 'h10B, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 12, 0, 'h000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h101, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 2, 2, 'h003, 1, 0));
    // SLPI 3 at line 2: three NOP cycles, then line 3.
    vecs.push_back(mk(0, 0, 1, 1, 0, 3, 2, 'h000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 2, 'h000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 2, 'h000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 3, 'h109, 1, 0));
    // SLP R with -5 and with 0: no stall.
    push_boot2(4);
    vecs.push_back(mk(0, 0, 1, 0, -5, 3, 3, 'h109, 1, 0));
    push_boot2(4);
    vecs.push_back(mk(0, 0, 1, 0, 0, 3, 3, 'h109, 1, 0));
    // SLP R 10, reset in its second sleep cycle, reboot.
    push_boot2(4);
    vecs.push_back(mk(0, 0, 1, 0, 10, 3, 2, 'h000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 2, 'h000, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 0, 'h000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 'h100, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 'h101, 1, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", 0, 64'(if16.pc), 64'd0);
    chk("reset_instr", 0, 64'(if16.instr), 64'd0);
    chk("reset_valid", 0, 64'(if16.instr_valid), 64'd0);
    chk("reset_sleeping", 0, 64'(if16.sleeping), 64'd0);
    chk("reset_state", 0, 64'(if16.state_dbg), 64'd0);
    chk("reset_rom_addr", 0, 64'(if16.rom_addr), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == rom_change_idx) begin
        rom16[2] = 31'h003;  // SLPI 3
        rom16[3] = 31'h109;  // JMPI 9
      end
      apply16(vecs[i], i);
    end
    rst16 = 1'b1;

    // 12-line program: jump target 15 folds to 0; wrap after line 11.
    step12(1, 0, 0, 0, 'h000, 0, 0);
    step12(0, 0, 0, 0, 'h100, 1, 1);
    step12(0, 0, 1, 1, 'h00F, 1, 2);
    step12(0, 1, 0, 0, 'h100, 1, 3);
    for (int k = 1; k <= 11; k++)
      step12(0, 0, k, k, (k == 1) ? 'h00F : ('h100 + k), 1, 3 + k);
    step12(0, 0, 0, 0, 'h100, 1, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch/sequencer stage that sits directly upstream of the opcode decoder LUT in the SHENZHEN-style core. It holds the program counter and drives the address of an external combinational program ROM. It registers the fetched 31-bit word as the decoder's `instr` input. It consumes the decoder's is_jmp / is_slp feedback to redirect the PC or stall for SLP. Program execution loops: the PC wraps from the last line back to 0.

Parameters:
PROG_DEPTH, 16, number of program lines; legal PCs are 0..PROG_DEPTH-1
ADDR_W, 4, PC/ROM address width, ≥ clog2(PROG_DEPTH)
SLP_W, 11, signed sleep-operand width (covers -999..999)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
rom_addr  out  ADDR_W  combinational address to program ROM
rom_data  in  31  combinational ROM read data for rom_addr
instr  out  31  registered instruction to decoder; NOP (all zero) when not valid
instr_valid  out  1  instr holds a real fetched line
pc  out  ADDR_W  address of the line currently in instr
sleeping  out  1  high while in SLEEP state
is_jmp  in  1  decoder flag for current instr
is_slp  in  1  decoder flag for current instr
slp_use_imm  in  1  decoder Da_or_Imm0; selects immediate sleep operand
slp_reg_val  in  SLP_W  register-file value for SLP R (signed)

Behaviour:
- States: BOOT, RUN, SLEEP. Synchronous reset from any state, including mid-sleep, forces:
  - state=BOOT
  - pc=0
  - instr=0
  - instr_valid=0
  - sleeping=0
  - internal sleep counter=0
- Reset therefore aborts a sleep in progress.
- Field definitions:
  - Immediate field: instr[SLP_W-1:0], signed.
  - Jump target: instr[ADDR_W-1:0]. A target ≥ PROG_DEPTH is replaced by 0.
  - pc_next = (pc==PROG_DEPTH-1) ? 0 : pc+1.
- Sleep operand n:
  - slp_use_imm=1: n = immediate field.
  - slp_use_imm=0: n = slp_reg_val.
  - n is signed.
- BOOT:
  - rom_addr=0.
  - Next edge: instr<=rom_data, pc<=0, instr_valid<=1, state<=RUN.
- RUN, priority is_jmp > is_slp > sequential; the decoder never asserts both:
  - is_jmp: rom_addr=target. Next edge: instr<=rom_data, pc<=target. No bubble.
  - is_slp with n≤0: behaves as a sequential step, no stall.
  - is_slp with n>0: rom_addr=pc_next (ignored).
    - Next edge: state<=SLEEP, cnt<=n, instr<=0, instr_valid<=0, sleeping<=1.
    - pc holds the SLP line's address.
  - Otherwise: rom_addr=pc_next. Next edge: instr<=rom_data, pc<=pc_next.
- SLEEP:
  - rom_addr=pc_next. cnt decrements every edge.
  - On the edge where cnt==1: instr<=rom_data, pc<=pc_next, instr_valid<=1, sleeping<=0, state<=RUN.
  - Exactly n cycles have instr_valid=0 between the SLP cycle and the next instruction.
- Latency:
  - rom_addr → instr is 1 edge.
  - Decoder flags are evaluated in the same cycle that instr is presented.
  - The path instr → decoder → is_jmp → rom_addr → rom_data → instr D-input is combinational by design. It contains no loop, because instr is registered.
- Wrap-around: sequential step from PROG_DEPTH-1 goes to 0. A jump to the current pc re-fetches the same line each cycle (legal busy loop).
- Width rules:
  - cnt is SLP_W-1 bits unsigned and is loaded only when n>0.
  - Maximum n is 2^(SLP_W-1)-1; there is no saturation beyond that.

Test Plan:
- Reset release, ROM holds addr k → word 0x100+k, no flags. Required response:
  - rom_addr=0 in BOOT.
  - Cycle 1: instr=0x100, pc=0, valid=1.
  - pc then steps 1,2,…,15,0 (wrap), and instr tracks rom_data each cycle.
- Line 3 decodes as JMPI with instr[3:0]=9 (is_jmp=1 while pc=3). Required response: next cycle pc=9, instr=ROM[9], no invalid cycle.
- Line 2 is SLPI with imm=3 (is_slp=1, slp_use_imm=1). Required response:
  - Next 3 cycles: instr_valid=0, instr=0, sleeping=1, pc=2.
  - 4th cycle: pc=3, instr=ROM[3], valid=1.
- SLP R with slp_reg_val=-5, then repeated with 0. Required response: no stall; pc advances 2→3 on the next edge.
- reset asserted in the 2nd cycle of a 10-cycle sleep. Required response:
  - Outputs return to reset values.
  - BOOT follows, and pc=0 is fetched one cycle after reset deasserts.
- JMPI target 15 with PROG_DEPTH=12. Required response: pc=0, instr=ROM[0]. Then a sequential step from pc=11 gives pc=0.
